// File: rtl/fmap_ram_if.sv
// Bus bundle for fmap_ram_ctrl: clear control, per-channel write/read ports and status.
// The master drives requests; the slave (the controller) returns read data and status.
interface fmap_ram_if #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic                       start;
    logic [NUM_CH-1:0]          we;
    logic [NUM_CH*ADDR_W-1:0]   wr_addr;
    logic [NUM_CH*DATA_W-1:0]   wr_data;
    logic [NUM_CH-1:0]          rd_en;
    logic [NUM_CH*ADDR_W-1:0]   rd_addr;
    logic [NUM_CH*DATA_W-1:0]   rd_data;
    logic [NUM_CH-1:0]          rd_valid;
    logic                       busy;
    logic                       init_done;
    logic                       addr_err;
    logic [1:0]                 dbg_state;

    // Handshake: rd_en[c] is a request taken every cycle the block is not busy (no
    // backpressure); rd_valid[c] marks the matching response a fixed latency later.
    // we[c] writes take effect at the sampling edge; start is a one-cycle pulse.
    modport master (
        output start, we, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, init_done, addr_err, dbg_state
    );
    modport slave (
        input  start, we, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, init_done, addr_err, dbg_state
    );
endinterface

// File: rtl/fmap_ram_ctrl.sv
// Multi-channel feature-map RAM controller: per-channel 1W/1R RAMs, write-first forwarding,
// bulk clear FSM, sticky range error. Define FMAP_RAM_OUTREG_EN for a latency-2 read path.
module fmap_ram_ctrl #(
    parameter int                 NUM_CH    = 6,
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 14,
    parameter int                 DEPTH     = 16384,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    fmap_ram_if.slave    bus
);
    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_X  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, READY = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cnt, cnt_nxt;
    logic               go_clear;
    logic               last;
    logic               init_done_q;
    logic               addr_err_q;
    logic [NUM_CH-1:0]  err_vec;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_clear  = 1'b0;
        last      = ({1'b0, cnt} == LAST_X);
        case (state)
            IDLE, READY: begin
                if (bus.start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    go_clear  = 1'b1;
                end
            end
            CLEAR: begin
                if (last) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            init_done_q <= (state == CLEAR) && last;
        end
    end

    // A range error in the same cycle as start wins, so that access is not forgotten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          addr_err_q <= 1'b0;
        else if (|err_vec) addr_err_q <= 1'b1;
        else if (go_clear) addr_err_q <= 1'b0;
    end

    assign bus.busy      = (state == CLEAR);
    assign bus.init_done = init_done_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.dbg_state = state;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] wa, ra;
        logic [DATA_W-1:0] wd;
        logic              wr_in, rd_in, wr_ok, user;
        logic [DATA_W-1:0] rq;
        logic              rv;

        assign wa    = bus.wr_addr[c*ADDR_W +: ADDR_W];
        assign ra    = bus.rd_addr[c*ADDR_W +: ADDR_W];
        assign wd    = bus.wr_data[c*DATA_W +: DATA_W];
        assign wr_in = ({1'b0, wa} < DEPTH_X);
        assign rd_in = ({1'b0, ra} < DEPTH_X);
        assign user  = (state != CLEAR);
        assign wr_ok = user && bus.we[c] && wr_in;
        assign err_vec[c] = user && ((bus.we[c] && !wr_in) || (bus.rd_en[c] && !rd_in));

        always_ff @(posedge clk) begin
            if (state == CLEAR)
                mem[cnt[IDX_W-1:0]] <= CLEAR_VAL;
            else if (wr_ok)
                mem[wa[IDX_W-1:0]] <= wd;
        end

        // A read issued with the accepted start pulse is dropped: no valid may appear while busy.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rq <= '0;
                rv <= 1'b0;
            end else if (!user || go_clear) begin
                rv <= 1'b0;
            end else if (bus.rd_en[c]) begin
                rv <= 1'b1;
                if (!rd_in)
                    rq <= '0;
                else if (wr_ok && (wa == ra))
                    rq <= wd;
                else
                    rq <= mem[ra[IDX_W-1:0]];
            end else begin
                rv <= 1'b0;
            end
        end

`ifdef FMAP_RAM_OUTREG_EN
        logic [DATA_W-1:0] rq2;
        logic              rv2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rq2 <= '0;
                rv2 <= 1'b0;
            end else if (!user) begin
                rv2 <= 1'b0;
            end else begin
                rv2 <= rv;
                if (rv) rq2 <= rq;
            end
        end

        assign bus.rd_data[c*DATA_W +: DATA_W] = rq2;
        assign bus.rd_valid[c]                 = rv2;
`else
        assign bus.rd_data[c*DATA_W +: DATA_W] = rq;
        assign bus.rd_valid[c]                 = rv;
`endif
    end
endmodule

// File: tb/tb_fmap_ram_ctrl.sv
// Self-checking bench for fmap_ram_ctrl (DEPTH=16): directed vectors, expected read
// responses queued at issue time and matched by an independent monitor.
module tb_fmap_ram_ctrl;
    localparam int NUM_CH = 6;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmap_ram_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fmap_ram_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int busy_cycles = 0;
    int done_pulses = 0;
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_wr(input int ch, input int addr, input logic [7:0] d);
        bus.we[ch] = 1'b1;
        bus.wr_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        bus.wr_data[ch*DATA_W +: DATA_W] = d;
    endtask

    // Calls within one cycle must go in ascending channel order (monitor pops in that order).
    task automatic set_rd(input int ch, input int addr, input logic [7:0] e);
        bus.rd_en[ch] = 1'b1;
        bus.rd_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        exp_q.push_back({3'(ch), e});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.we    = '0;
        bus.rd_en = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step;
    endtask

    task automatic run_clear(input string tag);
        busy_cycles = 0;
        done_pulses = 0;
        bus.start = 1'b1;
        step;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            if (i == 3) bus.start = 1'b1;
            if (i == 10) begin
                set_wr(4, 2, 8'hEE);
                bus.rd_en = '1;
            end
            step;
        end
        step;
        step;
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd16);
        chk({tag, "_init_done_pulses"}, 64'(done_pulses), 64'd1);
    endtask

    always @(negedge clk) begin
        if (bus.busy) busy_cycles++;
        if (bus.init_done) done_pulses++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.rd_valid[c]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected ch%0d: got data %0h, expected no response",
                             c, bus.rd_data[c*DATA_W +: DATA_W]);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    if (e[10:8] != 3'(c) || e[7:0] !== bus.rd_data[c*DATA_W +: DATA_W]) begin
                        n_err++;
                        $display("FAIL rd_data ch%0d: got %0h, expected ch%0d data %0h",
                                 c, bus.rd_data[c*DATA_W +: DATA_W], e[10:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.we      = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_valid",  64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data",   64'(bus.rd_data), 64'd0);
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
        chk("rst_addr_err",  64'(bus.addr_err), 64'd0);
        chk("rst_state",     64'(bus.dbg_state), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full clear, then every word of every channel reads CLEAR_VAL.
        run_clear("clr1");
        for (int a = 0; a < DEPTH; a++) begin
            for (int c = 0; c < NUM_CH; c++) set_rd(c, a, 8'h00);
            step;
        end

        // Write then read back on one channel.
        set_wr(3, 5, 8'hA7); step;
        set_rd(3, 5, 8'hA7); step;

        // Same-address collision forwards write data; different address reads old content.
        set_wr(0, 9, 8'h3C); set_rd(0, 9, 8'h3C); step;
        set_wr(0, 10, 8'h55); step;
        set_wr(0, 9, 8'h11); set_rd(0, 10, 8'h55); step;
        set_rd(0, 9, 8'h11); step;

        // Out-of-range read/write: zero data, dropped write, sticky error cleared by start.
        drain(4);
        chk("err_before", 64'(bus.addr_err), 64'd0);
        set_rd(1, 20, 8'h00); step;
        set_wr(2, 20, 8'h99); step;
        set_rd(2, 4, 8'h00); step;
        drain(3);
        chk("err_sticky", 64'(bus.addr_err), 64'd1);
        run_clear("clr2");
        chk("err_cleared", 64'(bus.addr_err), 64'd0);

        // Reset in the middle of a clear leaves later words untouched.
        set_wr(5, 12, 8'h5A); step;
        set_wr(5, 3, 8'h33); step;
        done_pulses = 0;
        bus.start = 1'b1; step;
        drain(7);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",     64'(bus.busy), 64'd0);
        chk("abort_rd_valid", 64'(bus.rd_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drain(2);
        chk("abort_state",     64'(bus.dbg_state), 64'd0);
        chk("abort_no_done",   64'(done_pulses), 64'd0);
        set_rd(5, 12, 8'h5A); step;
        set_rd(5, 3, 8'h00); step;
        drain(3);
        run_clear("clr3");
        set_rd(5, 12, 8'h00); step;

        // All channels in parallel: own data back, no cross-talk.
        for (int c = 0; c < NUM_CH; c++) set_wr(c, c + 2, 8'(17 * (c + 1)));
        step;
        for (int c = 0; c < NUM_CH; c++) begin
            set_wr(c, c + 8, 8'hF0 | 8'(c));
            set_rd(c, c + 2, 8'(17 * (c + 1)));
        end
        step;
        for (int c = 0; c < NUM_CH; c++) set_rd(c, c + 8, 8'hF0 | 8'(c));
        step;
        for (int c = 0; c < NUM_CH; c++) set_rd(c, c + 3, 8'h00);
        step;

        drain(5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
